// File: rtl/alu_exec_stage_if.sv
// Handshake bundle between the ALU-control decoder, the execute stage and EX/MEM.
// The slave modport is the execute stage; the master modport is its upstream/downstream environment.
interface alu_exec_stage_if #(
  parameter int WIDTH = 32,
  parameter int REGW  = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       alu_control;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic [REGW-1:0]  dest_in;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             overflow;
  logic             illegal;
  logic [REGW-1:0]  dest_out;

  modport slave (
    input  in_valid, alu_control, operand_a, operand_b, dest_in, flush, out_ready,
    output in_ready, out_valid, result, zero, overflow, illegal, dest_out
  );

  modport master (
    output in_valid, alu_control, operand_a, operand_b, dest_in, flush, out_ready,
    input  in_ready, out_valid, result, zero, overflow, illegal, dest_out
  );
endinterface

// File: rtl/alu_exec_stage.sv
// MIPS execute stage: ADD/SUB/AND/OR/NOR/SLT into a registered EX/MEM slot
// backed by a one-entry skid buffer so in_ready is purely registered.
module alu_exec_stage #(
  parameter int WIDTH = 32,
  parameter int REGW  = 5
) (
  input  logic           clk,
  input  logic           reset,
  alu_exec_stage_if.slave bus
);
  localparam int PW = WIDTH + REGW + 3;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_NOR = 3'd4;
  localparam logic [2:0] OP_SLT = 3'd5;

  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_res;
  logic             w_ovf;
  logic             w_ill;
  logic             w_zero;
  logic             w_a_msb;
  logic             w_b_msb;
  logic [PW-1:0]    w_payload;
  logic             w_in_xfer;
  logic             w_or_free;

  logic             r_or_valid;
  logic [PW-1:0]    r_or_data;
  logic             r_sk_valid;
  logic [PW-1:0]    r_sk_data;

  assign w_a_msb = bus.operand_a[WIDTH-1];
  assign w_b_msb = bus.operand_b[WIDTH-1];
  assign w_sum   = bus.operand_a + bus.operand_b;
  assign w_diff  = bus.operand_a - bus.operand_b;

  always_comb begin
    w_res = '0;
    w_ovf = 1'b0;
    w_ill = 1'b0;
    case (bus.alu_control)
      OP_ADD: begin
        w_res = w_sum;
        w_ovf = (w_a_msb == w_b_msb) && (w_sum[WIDTH-1] != w_a_msb);
      end
      OP_SUB: begin
        w_res = w_diff;
        w_ovf = (w_a_msb != w_b_msb) && (w_diff[WIDTH-1] != w_a_msb);
      end
      OP_AND: w_res = bus.operand_a & bus.operand_b;
      OP_OR:  w_res = bus.operand_a | bus.operand_b;
      OP_NOR: w_res = ~(bus.operand_a | bus.operand_b);
      OP_SLT: w_res = {{(WIDTH-1){1'b0}}, ($signed(bus.operand_a) < $signed(bus.operand_b))};
      default: w_ill = 1'b1;
    endcase
    w_zero = (w_res == '0);
  end

  // Payload layout: {dest, illegal, overflow, zero, result}
  assign w_payload = {bus.dest_in, w_ill, w_ovf, w_zero, w_res};
  assign w_in_xfer = bus.in_valid && !r_sk_valid;
  assign w_or_free = !r_or_valid || bus.out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_or_valid <= 1'b0;
      r_or_data  <= '0;
      r_sk_valid <= 1'b0;
      r_sk_data  <= '0;
    end else if (bus.flush) begin
      r_or_valid <= 1'b0;
      r_or_data  <= '0;
      r_sk_valid <= 1'b0;
      r_sk_data  <= '0;
    end else if (w_or_free) begin
      // A held skid entry always goes first; input is blocked while it is full.
      if (r_sk_valid) begin
        r_or_valid <= 1'b1;
        r_or_data  <= r_sk_data;
        r_sk_valid <= 1'b0;
      end else if (w_in_xfer) begin
        r_or_valid <= 1'b1;
        r_or_data  <= w_payload;
      end else begin
        r_or_valid <= 1'b0;
      end
    end else if (w_in_xfer) begin
      r_sk_valid <= 1'b1;
      r_sk_data  <= w_payload;
    end
  end

  assign bus.in_ready  = !r_sk_valid;
  assign bus.out_valid = r_or_valid;
  assign bus.result    = r_or_data[WIDTH-1:0];
  assign bus.zero      = r_or_data[WIDTH];
  assign bus.overflow  = r_or_data[WIDTH+1];
  assign bus.illegal   = r_or_data[WIDTH+2];
  assign bus.dest_out  = r_or_data[PW-1:WIDTH+3];
endmodule

// File: tb/tb_alu_exec_stage.sv
// Scoreboard bench for alu_exec_stage: the driver queues hand-computed results on
// each accepted op, and a negedge monitor checks every presented output against the queue head.
module tb_alu_exec_stage;
  typedef struct {
    logic [31:0] res;
    logic        z;
    logic        o;
    logic        il;
    logic [4:0]  d;
  } exp_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  exp_t q[$];

  alu_exec_stage_if #(.WIDTH(32), .REGW(5)) bus ();

  alu_exec_stage #(.WIDTH(32), .REGW(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: outputs are sampled mid-cycle; a pop happens only where the next edge transfers.
  always @(negedge clk) begin
    if (!reset && !bus.flush && bus.out_valid) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output actual=dest%0d/res%h required=none", bus.dest_out, bus.result);
      end else begin
        if (bus.result !== q[0].res || bus.zero !== q[0].z || bus.overflow !== q[0].o ||
            bus.illegal !== q[0].il || bus.dest_out !== q[0].d) begin
          errors++;
          $display("FAIL out_txn actual=d%0d r=%h z%b o%b i%b required=d%0d r=%h z%b o%b i%b",
                   bus.dest_out, bus.result, bus.zero, bus.overflow, bus.illegal,
                   q[0].d, q[0].res, q[0].z, q[0].o, q[0].il);
        end
        if (bus.out_ready) begin
          $display("OUT dest=%0d result=%h zero=%b ovf=%b ill=%b",
                   bus.dest_out, bus.result, bus.zero, bus.overflow, bus.illegal);
          void'(q.pop_front());
        end
      end
    end
  end

  task automatic drive(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] d);
    bus.in_valid    = 1'b1;
    bus.alu_control = c;
    bus.operand_a   = a;
    bus.operand_b   = b;
    bus.dest_in     = d;
  endtask

  task automatic send(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] d, input logic [31:0] er, input logic ez,
                      input logic eo, input logic ei);
    exp_t e;
    logic rdy;
    bit   accepted;
    e.res = er; e.z = ez; e.o = eo; e.il = ei; e.d = d;
    drive(c, a, b, d);
    accepted = 0;
    for (int n = 0; n < 20 && !accepted; n++) begin
      @(negedge clk);
      rdy = bus.in_ready;
      @(posedge clk);
      if (rdy) begin
        q.push_back(e);
        $display("IN  ctrl=%0d a=%h b=%h dest=%0d", c, a, b, d);
        accepted = 1;
      end
      #1;
    end
    if (!accepted) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout actual=0 required=1 dest=%0d", d);
    end
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    for (int n = 0; n < 30 && q.size() != 0; n++) begin
      @(posedge clk);
      #1;
    end
    check("queue_drained", q.size(), 0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.alu_control = 3'd0;
    bus.operand_a = '0;
    bus.operand_b = '0;
    bus.dest_in = '0;
    bus.flush = 1'b0;
    bus.out_ready = 1'b1;

    #12;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_result", bus.result, 0);
    check("rst_flags", {bus.zero, bus.overflow, bus.illegal}, 0);
    check("rst_dest", bus.dest_out, 0);
    #1 reset = 1'b0;
    @(posedge clk); #1;

    // Directed ALU vectors with out_ready held high
    send(3'd0, 32'h7FFFFFFF, 32'h00000001, 5'd1, 32'h80000000, 0, 1, 0);
    send(3'd1, 32'd5,        32'd5,        5'd2, 32'h00000000, 1, 0, 0);
    send(3'd1, 32'h80000000, 32'h00000001, 5'd3, 32'h7FFFFFFF, 0, 1, 0);
    send(3'd5, 32'hFFFFFFFF, 32'h00000001, 5'd4, 32'h00000001, 0, 0, 0);
    send(3'd4, 32'h00000000, 32'h00000000, 5'd5, 32'hFFFFFFFF, 0, 0, 0);
    send(3'd7, 32'h12345678, 32'h9ABCDEF0, 5'd6, 32'h00000000, 1, 0, 1);
    send(3'd2, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd7, 32'h00F000F0, 0, 0, 0);
    send(3'd3, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd8, 32'hFFF0FFF0, 0, 0, 0);
    send(3'd5, 32'h00000001, 32'hFFFFFFFF, 5'd9, 32'h00000000, 1, 0, 0);
    send(3'd1, 32'h00000000, 32'h00000001, 5'd10, 32'hFFFFFFFF, 0, 0, 0);
    send(3'd0, 32'h80000000, 32'h80000000, 5'd11, 32'h00000000, 1, 1, 0);
    send(3'd6, 32'h00000003, 32'h00000004, 5'd12, 32'h00000000, 1, 0, 1);
    idle(1);
    @(negedge clk);
    check("valid_falls_when_idle", bus.out_valid, 0);
    drain();

    // Stall: two ops fill OR and SK, third must wait until the skid empties
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    send(3'd0, 32'd10, 32'd20, 5'd1, 32'd30, 0, 0, 0);
    send(3'd0, 32'd11, 32'd21, 5'd2, 32'd32, 0, 0, 0);
    drive(3'd0, 32'd12, 32'd22, 5'd3);
    @(negedge clk);
    check("stall_in_ready_low", bus.in_ready, 0);
    check("stall_out_valid", bus.out_valid, 1);
    check("stall_head_dest", bus.dest_out, 1);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    send(3'd0, 32'd12, 32'd22, 5'd3, 32'd34, 0, 0, 0);
    idle(1);
    drain();

    // Flush with OR and SK full plus a simultaneous input
    bus.out_ready = 1'b0;
    send(3'd3, 32'h1, 32'h2, 5'd20, 32'h3, 0, 0, 0);
    send(3'd3, 32'h4, 32'h8, 5'd21, 32'hC, 0, 0, 0);
    drive(3'd0, 32'h5, 32'h6, 5'd22);
    bus.flush = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    q.delete();
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("flush_out_valid", bus.out_valid, 0);
    check("flush_in_ready", bus.in_ready, 1);
    repeat (3) begin
      @(negedge clk);
      check("flush_no_stale", bus.out_valid, 0);
    end

    // Asynchronous reset between edges while a result is held
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    send(3'd0, 32'd100, 32'd23, 5'd9, 32'd123, 0, 0, 0);
    bus.in_valid = 1'b0;
    #3;
    reset = 1'b1;
    #1;
    check("async_rst_out_valid", bus.out_valid, 0);
    check("async_rst_result", bus.result, 0);
    check("async_rst_in_ready", bus.in_ready, 1);
    q.delete();
    @(negedge clk);
    #2 reset = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    send(3'd0, 32'd1, 32'd1, 5'd5, 32'd2, 0, 0, 0);
    idle(1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_exec_stage.md
Name: alu_exec_stage

Overview:
Execute stage of the basic MIPS datapath, directly downstream of the ALU control decoder. Consumes the 3-bit ALU control code with two operands and a destination register index, and computes ADD/SUB/AND/OR/NOR/SLT. Results, zero flag (for BEQ) and signed overflow go into a registered EX/MEM output. A valid/ready handshake with a one-entry skid buffer lets the memory stage stall without combinational ready paths.

Parameters:
WIDTH, 32, operand/result width in bits
REGW, 5, destination register index width

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
in_valid  input  1  upstream holds a valid operation
in_ready  output  1  stage can accept; registered (driven from skid-buffer empty flag)
alu_control  input  3  0=ADD 1=SUB 2=AND 3=OR 4=NOR 5=SLT; 6,7 illegal
operand_a  input  WIDTH  first operand (rs)
operand_b  input  WIDTH  second operand (rt or sign-extended immediate)
dest_in  input  REGW  destination register index
flush  input  1  synchronous squash of all held and incoming operations
out_valid  output  1  output register holds a result
out_ready  input  1  downstream accepts this cycle
result  output  WIDTH  registered ALU result
zero  output  1  result == 0
overflow  output  1  signed overflow (ADD/SUB only)
illegal  output  1  alu_control was 6 or 7
dest_out  output  REGW  registered destination index

Behaviour:
- Reset (async, asserted): out_valid=0, in_ready=1, skid empty, result=0, zero=0, overflow=0, illegal=0, dest_out=0.
- Transfer in: in_valid & in_ready at clock edge. Transfer out: out_valid & out_ready.
- Computation combinational on inputs, captured at transfer in; latency 1 cycle (accepted at edge N, visible at outputs after edge N).
- ADD: a+b mod 2^WIDTH; overflow = operand signs equal and result sign differs.
- SUB: a-b mod 2^WIDTH; overflow = operand signs differ and result sign differs from a.
- AND/OR/NOR bitwise; overflow=0.
- SLT: result = {WIDTH-1 zeros, (signed a < signed b)}; overflow=0.
- Codes 6,7: result=0, zero=1, overflow=0, illegal=1; still a normal transfer (no drop).
- zero computed from the final result being registered, never from stale data.
- Storage: output register (OR) + skid register (SK).
  - OR empty or draining this cycle: incoming op goes to OR.
  - OR full and not draining, in_ready=1: incoming op goes to SK; in_ready drops to 0 next cycle.
  - OR drains while SK full: SK moves to OR, SK empties, in_ready=1 next cycle. No input accepted while SK full.
  - Output order strictly equals input order; no op lost or duplicated.
- out_valid and all output fields stable while out_valid=1 & out_ready=0.
- flush=1: at that edge OR and SK cleared (out_valid=0), any same-cycle input discarded, in_ready=1 next cycle. Flush wins over every simultaneous event, including out_ready.
- Reset mid-operation: everything cleared immediately, regardless of clock.
- in_valid deasserted with OR full and out_ready=1: out_valid falls to 0 next cycle.

Test Plan:
- ADD 0x7FFFFFFF + 0x00000001, out_ready=1 -> next cycle result=0x80000000, overflow=1, zero=0, out_valid=1.
- SUB 5-5 (BEQ case, code 1) -> result=0, zero=1, overflow=0; SUB 0x80000000-1 -> result=0x7FFFFFFF, overflow=1.
- SLT a=0xFFFFFFFF(-1), b=1 -> result=1; NOR 0,0 -> 0xFFFFFFFF; code 7 -> result=0, zero=1, illegal=1.
- Back-to-back stream of 3 ADDs (dest 1,2,3) with out_ready=0 for 3 cycles -> 2 accepted (OR+SK), in_ready=0; release out_ready -> dest_out 1,2,3 delivered in order, none lost.
- flush asserted with OR and SK full and in_valid=1 -> next cycle out_valid=0, in_ready=1, no stale result later.
- Async reset pulse between clock edges while out_valid=1 -> out_valid=0, result=0 immediately; normal operation resumes after release.
